// File: rtl/alu_share_arbiter.sv
// Two-way round-robin sequencer that time-shares one ALU between the integer
// execute stage (port 0) and the branch/address unit (port 1).
module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_aluop,
  input  logic [2:0]      req0_funct3,
  input  logic [6:0]      req0_funct7,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_aluop,
  input  logic [2:0]      req1_funct3,
  input  logic [6:0]      req1_funct7,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [1:0]      alu_aluop,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            busy,
  output logic            owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic            grant_s;
  logic            accept_s;
  logic            rsp_take_s;
  logic            last_served_r;
  logic            owner_r;
  logic            busy_r;
  logic            rsp0_valid_r;
  logic            rsp1_valid_r;
  logic [1:0]      aluop_r;
  logic [2:0]      funct3_r;
  logic [6:0]      funct7_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;
  logic [XLEN-1:0] result_r;
  logic [1:0]      sel_aluop_s;
  logic [2:0]      sel_funct3_s;
  logic [6:0]      sel_funct7_s;
  logic [XLEN-1:0] sel_a_s;
  logic [XLEN-1:0] sel_b_s;

  // Round-robin grant: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_served_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s   = (state_r == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept_s && !grant_s;
  assign req1_ready = accept_s && grant_s;
  assign rsp_take_s = owner_r ? rsp1_ready : rsp0_ready;

  // Operand mux from the granted port into the operation registers.
  always_comb begin
    sel_aluop_s  = req0_aluop;
    sel_funct3_s = req0_funct3;
    sel_funct7_s = req0_funct7;
    sel_a_s      = req0_a;
    sel_b_s      = req0_b;
    if (grant_s) begin
      sel_aluop_s  = req1_aluop;
      sel_funct3_s = req1_funct3;
      sel_funct7_s = req1_funct7;
      sel_a_s      = req1_a;
      sel_b_s      = req1_b;
    end else begin
      sel_aluop_s  = req0_aluop;
      sel_funct3_s = req0_funct3;
      sel_funct7_s = req0_funct7;
      sel_a_s      = req0_a;
      sel_b_s      = req0_b;
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = EXEC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      EXEC: state_nx_s = RESP;
      RESP: begin
        if (rsp_take_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register plus registered status flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      busy_r       <= (state_nx_s != IDLE);
      rsp0_valid_r <= (state_nx_s == RESP) && !owner_r;
      rsp1_valid_r <= (state_nx_s == RESP) && owner_r;
    end
  end

  // Operation registers and owner, loaded only on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluop_r  <= 2'd0;
      funct3_r <= 3'd0;
      funct7_r <= 7'd0;
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
      owner_r  <= 1'b0;
    end else if (accept_s) begin
      aluop_r  <= sel_aluop_s;
      funct3_r <= sel_funct3_s;
      funct7_r <= sel_funct7_s;
      a_r      <= sel_a_s;
      b_r      <= sel_b_s;
      owner_r  <= grant_s;
    end
  end

  // Result capture at the end of EXEC; round-robin pointer moves on response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r      <= {XLEN{1'b0}};
      last_served_r <= 1'b1;
    end else begin
      if (state_r == EXEC) begin
        result_r <= alu_result;
      end
      if ((state_r == RESP) && rsp_take_s) begin
        last_served_r <= owner_r;
      end
    end
  end

  assign alu_aluop  = aluop_r;
  assign alu_funct3 = funct3_r;
  assign alu_funct7 = funct7_r;
  assign alu_a      = a_r;
  assign alu_b      = b_r;
  assign rsp_result = result_r;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign busy       = busy_r;
  assign owner      = owner_r;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and two-way round-robin arbiter that time-shares the core's single ALU (ALU control decoder plus ALU) between two requesters: port 0, the integer execute stage, and port 1, the branch/address unit. It accepts one operation at a time over a valid/ready handshake and registers the operation fields and operands. It drives those registered values to the shared ALU for one cycle, captures the result, and returns it to the originating requester over a second valid/ready handshake.

## Interface
- XLEN, 32, operand/result width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  arbiter accepts the request this cycle
- reqN_aluop  in  2  ALU-op class: 00 load/store add, 01 branch compare, 10 R-type
- reqN_funct3  in  3  instruction funct3
- reqN_funct7  in  7  instruction funct7
- reqN_a, reqN_b  in  XLEN  operands
- alu_aluop, alu_funct3, alu_funct7  out  2/3/7  to the shared ALU control decoder
- alu_a, alu_b  out  XLEN  to the shared ALU
- alu_result  in  XLEN  combinational ALU result for the driven alu_* values
- rsp0_valid / rsp1_valid  out  1  result available for port 0 / 1
- rsp0_ready / rsp1_ready  in  1  requester takes the result
- rsp_result  out  XLEN  result, shared by both response ports
- busy  out  1  high in every state except IDLE
- owner  out  1  port that owns the in-flight operation

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Grant = the single valid port. If both ports are valid, grant the port not equal to last_served. last_served resets to 1, so port 0 wins the first tie.
  - reqN_ready = (state==IDLE) & grant==N. Ready may depend combinationally on valid. At most one ready is high in any cycle.
  - On handshake, latch aluop, funct3, funct7, a and b into the operation registers, set owner=N, and go to EXEC.
- **EXEC**
  - alu_* outputs are driven from the operation registers at all times, never directly from the request ports.
  - At the end of EXEC, capture alu_result into rsp_result and go to RESP.
- **RESP**
  - rsp{owner}_valid = 1; the other rsp_valid stays 0.
  - On rsp{owner}_ready, set last_served=owner and return to IDLE.
  - If rsp_ready stays low, hold RESP indefinitely. rsp_result and all alu_* outputs stay stable.
- No request is accepted outside IDLE. A requester must hold valid and its fields stable until ready. A valid deasserted before grant is simply not served.
- Fields pass through unchecked. aluop=11 or unused funct3 codes still complete and return whatever alu_result the shared ALU produces.

## Timing
- Accept in cycle C → EXEC in C+1 → rsp_valid high from C+2. If rsp_ready is high in C+2, IDLE is in C+3 and the next accept can occur there. Peak throughput is one operation per 3 cycles.
- rsp_result is registered; it changes only at the EXEC→RESP edge.
- Reset values (asynchronous, effective immediately on rst_n low):
  - state=IDLE, owner=0, last_served=1, busy=0
  - all operation registers, alu_* outputs and rsp_result are 0
  - both rsp_valid are 0
  - req_ready follows IDLE rules once rst_n is high
- Reset asserted mid-operation in EXEC or RESP aborts it. No response is ever issued for the aborted request, and that requester must re-present it.
- Both req_valid high in the same cycle as the RESP→IDLE transition: the arbiter is not in IDLE that cycle, so nothing is accepted. Arbitration in the next cycle uses the updated last_served.

## Test plan
- **Reset defaults:** hold rst_n low mid-EXEC → all outputs 0, state IDLE, no rsp_valid after release. The first tie is granted to port 0.
- **Single R-type request:** req0 with aluop=10, funct3=000, funct7=0000000, a=5, b=7, and the ALU model returns a+b → req0_ready in cycle C; alu_* = (10, 000, 0000000, 5, 7) in C+1; rsp0_valid=1 and rsp_result=12 in C+2; rsp1_valid stays 0.
- **Tie / round-robin:** both ports valid continuously with rsp_ready=1 → grants alternate 0,1,0,1, one accept every 3 cycles. Verify owner and the matching rsp_valid each time.
- **Response backpressure:** rsp1_ready held low for 10 cycles after a port-1 branch op (aluop=01, funct3=100) → rsp1_valid, rsp_result and alu_* stable throughout. busy=1 and both req_ready=0 until rsp1_ready rises.
- **Field pass-through:** req0 aluop=11, funct3=111, a=0xFFFFFFFF → the op completes in 3 cycles and alu_* outputs match the request exactly.
- **Abort:** pulse rst_n low in cycle C+2 with rsp0_valid high → rsp0_valid drops immediately. A subsequent request completes normally with correct latency.
